// File: rtl/flit_pkg.sv
// ---------------------------------------------------------------------------
// flit_pkg : flit link constants, direction encodings and flit helper functions
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package flit_pkg;

  localparam int W_FLIT = 8;
  localparam int W_DIR  = 5;

  localparam int FLIT_V         = 7;
  localparam int FLIT_H         = 6;
  localparam int FLIT_T         = 5;
  localparam int FLIT_FIELD_LSB = 0;
  localparam int FLIT_FIELD_MSB = 4;
  localparam int W_FIELD        = FLIT_FIELD_MSB - FLIT_FIELD_LSB + 1;

  localparam logic [W_FIELD-1:0] DIR_N = 5'b00001;
  localparam logic [W_FIELD-1:0] DIR_E = 5'b00010;
  localparam logic [W_FIELD-1:0] DIR_S = 5'b00100;
  localparam logic [W_FIELD-1:0] DIR_W = 5'b01000;
  localparam logic [W_FIELD-1:0] DIR_L = 5'b10000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  function automatic logic isvalid(input logic [W_FLIT-1:0] flit);
    return flit[FLIT_V];
  endfunction

  function automatic logic is_head(input logic [W_FLIT-1:0] flit);
    return flit[FLIT_V] & flit[FLIT_H];
  endfunction

  function automatic logic is_tail(input logic [W_FLIT-1:0] flit);
    return flit[FLIT_V] & flit[FLIT_T];
  endfunction

  // Exactly one bit set; callers zero-extend narrower direction fields.
  function automatic logic onehot_ok(input logic [W_FIELD-1:0] dir);
    return $onehot(dir);
  endfunction

endpackage

`default_nettype wire

// File: rtl/flit_tx.sv
// ---------------------------------------------------------------------------
// flit_tx : serialises one-hot-routed messages into head/body/tail flits
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flit_tx
  import flit_pkg::*;
#(
  parameter int W_FLIT = flit_pkg::W_FLIT,
  parameter int W_DIR  = flit_pkg::W_DIR,
  parameter int N_BODY = 3,
  localparam int W_DATA = (N_BODY == 0) ? 1 : 5 * N_BODY
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [W_DIR-1:0]  IN_DIR,
  input  logic [W_DATA-1:0] IN_DATA,
  output logic [W_FLIT-1:0] OUT,
  input  logic              OUT_READY,
  output logic              ERR_DROP
);

  // Holding register is padded to at least one chunk so N_BODY=0 builds stay well-formed.
  localparam int   c_NCH       = (N_BODY == 0) ? 1 : N_BODY;
  localparam int   c_WPAD      = 5 * c_NCH;
  localparam logic c_HEAD_TAIL = (N_BODY == 0);

  tx_state_t           state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [c_WPAD-1:0]   data_q, data_d;
  logic [W_FLIT-1:0]   out_q, out_d;
  logic                err_q, err_d;

  logic                w_accept;
  logic                w_advance;
  logic                w_cur_tail;
  logic [3:0]          w_nidx;
  logic [W_FIELD-1:0]  w_dir;
  logic [W_FIELD-1:0]  w_chunk;
  logic [W_FLIT-1:0]   w_head;
  logic [W_FLIT-1:0]   w_body;

  assign w_cur_tail = is_tail(out_q);
  assign IN_READY   = (state_q == ST_IDLE) || (w_cur_tail && OUT_READY);
  assign w_accept   = IN_VALID && IN_READY;
  assign w_advance  = (state_q == ST_SEND) && OUT_READY;
  assign w_nidx     = idx_q + 4'd1;
  assign w_dir      = W_FIELD'(IN_DIR);

  always_comb begin
    w_chunk = '0;
    for (int k = 0; k < c_NCH; k++) begin
      if (w_nidx == 4'(k + 1)) w_chunk = data_q[5*k +: 5];
    end
  end

  assign w_head = {1'b1, 1'b1, c_HEAD_TAIL, w_dir};
  assign w_body = {1'b1, 1'b0, (w_nidx == 4'(N_BODY)), w_chunk};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    out_d   = out_q;
    err_d   = 1'b0;

    if (w_accept) begin
      // A new message (possibly right behind a tail) replaces whatever is on the bus.
      if (onehot_ok(w_dir)) begin
        state_d = ST_SEND;
        idx_d   = 4'd0;
        data_d  = c_WPAD'(IN_DATA);
        out_d   = w_head;
      end else begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        out_d   = '0;
        err_d   = 1'b1;
      end
    end else if (w_advance) begin
      if (w_cur_tail) begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        out_d   = '0;
      end else begin
        idx_d = w_nidx;
        out_d = w_body;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      data_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign OUT      = out_q;
  assign ERR_DROP = err_q;

endmodule

`default_nettype wire

// File: tb/tb_flit_tx.sv
// ---------------------------------------------------------------------------
// tb_flit_tx : directed self-checking bench for flit_tx (N_BODY=3 and N_BODY=0)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flit_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, in_ready, out_ready, err_drop;
  logic [4:0]  in_dir;
  logic [14:0] in_data;
  logic [7:0]  out;

  logic        in_valid0, in_ready0, out_ready0, err_drop0;
  logic [4:0]  in_dir0;
  logic [0:0]  in_data0;
  logic [7:0]  out0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  flit_tx #(.N_BODY(3)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DIR(in_dir), .IN_DATA(in_data),
    .OUT(out), .OUT_READY(out_ready), .ERR_DROP(err_drop)
  );

  flit_tx #(.N_BODY(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .IN_VALID(in_valid0), .IN_READY(in_ready0), .IN_DIR(in_dir0), .IN_DATA(in_data0),
    .OUT(out0), .OUT_READY(out_ready0), .ERR_DROP(err_drop0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    in_valid = 0; in_dir = '0; in_data = '0; out_ready = 1'b1;
    in_valid0 = 0; in_dir0 = '0; in_data0 = '0; out_ready0 = 1'b1;
    tick();
    chk("reset_out", out, 8'h00);
    chk("reset_err", {7'd0, err_drop}, 8'h00);
    chk("reset_rdy", {7'd0, in_ready}, 8'h01);
    RST = 1'b0;
    tick();

    // Basic message
    in_valid = 1; in_dir = 5'b00100; in_data = 15'h1A5B;
    tick();
    in_valid = 0; in_dir = 5'b01010; in_data = 15'h7FFF;
    chk("basic_head", out, 8'hC4);
    chk("basic_rdy1", {7'd0, in_ready}, 8'h00);
    tick();
    chk("basic_b1", out, 8'h9B);
    chk("basic_rdy2", {7'd0, in_ready}, 8'h00);
    tick();
    chk("basic_b2", out, 8'h92);
    chk("basic_rdy3", {7'd0, in_ready}, 8'h00);
    tick();
    chk("basic_tail", out, 8'hA6);
    chk("basic_rdy_tail", {7'd0, in_ready}, 8'h01);
    tick();
    chk("basic_idle", out, 8'h00);

    // Backpressure on body-2
    in_valid = 1; in_dir = 5'b00100; in_data = 15'h1A5B;
    tick();
    in_valid = 0;
    chk("bp_head", out, 8'hC4);
    tick();
    chk("bp_b1", out, 8'h9B);
    tick();
    out_ready = 0;
    chk("bp_hold0", out, 8'h92);
    chk("bp_rdy", {7'd0, in_ready}, 8'h00);
    tick();
    chk("bp_hold1", out, 8'h92);
    tick();
    chk("bp_hold2", out, 8'h92);
    tick();
    chk("bp_hold3", out, 8'h92);
    out_ready = 1;
    // Back-to-back message presented while the tail is on the bus
    tick();
    chk("bp_tail", out, 8'hA6);
    in_valid = 1; in_dir = 5'b00001; in_data = 15'h0000;
    chk("b2b_rdy", {7'd0, in_ready}, 8'h01);
    tick();
    in_valid = 0;
    chk("b2b_head", out, 8'hC1);
    tick();
    chk("b2b_b1", out, 8'h80);
    tick();
    chk("b2b_b2", out, 8'h80);
    tick();
    chk("b2b_tail", out, 8'hA0);
    tick();
    chk("b2b_idle", out, 8'h00);

    // Illegal directions
    in_valid = 1; in_dir = 5'b00000;
    tick();
    in_valid = 0;
    chk("ill0_out", out, 8'h00);
    chk("ill0_err", {7'd0, err_drop}, 8'h01);
    tick();
    chk("ill0_err_end", {7'd0, err_drop}, 8'h00);
    chk("ill0_out2", out, 8'h00);
    in_valid = 1; in_dir = 5'b00011;
    tick();
    in_valid = 0;
    chk("ill3_out", out, 8'h00);
    chk("ill3_err", {7'd0, err_drop}, 8'h01);
    tick();
    chk("ill3_err_end", {7'd0, err_drop}, 8'h00);

    // Illegal direction back-to-back after a tail
    in_valid = 1; in_dir = 5'b01000; in_data = 15'h0421;
    tick();
    in_valid = 0;
    chk("b2bi_head", out, 8'hC8);
    tick();
    chk("b2bi_b1", out, 8'h81);
    tick();
    chk("b2bi_b2", out, 8'h81);
    tick();
    chk("b2bi_tail", out, 8'hA1);
    in_valid = 1; in_dir = 5'b11000;
    tick();
    in_valid = 0;
    chk("b2bi_out", out, 8'h00);
    chk("b2bi_err", {7'd0, err_drop}, 8'h01);
    tick();

    // Reset mid-message
    in_valid = 1; in_dir = 5'b00010; in_data = 15'h1A5B;
    tick();
    in_valid = 0;
    chk("rst_head", out, 8'hC2);
    tick();
    chk("rst_b1", out, 8'h9B);
    #2 RST = 1'b1;
    #1;
    chk("rst_async", out, 8'h00);
    tick();
    RST = 1'b0;
    chk("rst_rdy", {7'd0, in_ready}, 8'h01);
    in_valid = 1; in_dir = 5'b10000; in_data = 15'h0003;
    tick();
    in_valid = 0;
    chk("rst_new_head", out, 8'hD0);
    tick();
    chk("rst_new_b1", out, 8'h83);

    // N_BODY=0 build
    in_valid0 = 1; in_dir0 = 5'b10000; in_data0 = 1'b1;
    tick();
    in_valid0 = 0;
    chk("nb0_flit", out0, 8'hF0);
    chk("nb0_rdy", {7'd0, in_ready0}, 8'h01);
    tick();
    chk("nb0_idle", out0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
